// File: rtl/instr_fetch_if.sv
// Fetch-to-decode handshake bundle.
// master side is the fetch buffer, slave side is decode.
interface instr_fetch_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_misalign;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        output out_misalign,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_misalign,
        output out_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch front end: owns the PC, buffers fetched words for decode.
// Optional IFETCH_ALIGN_CHECK_EN: a misaligned redirect halts fetch and queues a marker.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_instr,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    instr_fetch_if.master fetch_out
);
    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;

    state_t           state_q;
    state_t           state_d;
    fetch_entry_t     buf_q [FIFO_DEPTH];
    fetch_entry_t     head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      fetch_pc;
    logic [31:0]      load_pc;
    logic             bad_redirect;
    logic             pop;
    logic             push;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign load_pc      = redirect_pc;
`else
    assign bad_redirect = 1'b0;
    assign load_pc      = redirect_pc & ~32'h3;
`endif

    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = bad_redirect ? HALT : RUN;
        end
    end

    always_comb begin
        head                   = buf_q[rd_ptr];
        fetch_out.out_valid    = (count != '0);
        pop                    = fetch_out.out_valid && fetch_out.out_ready;
        push                   = (state_q == RUN) && !redirect_valid
                                 && ((count < DEPTH_C) || pop);
        fetch_out.out_instr    = fetch_out.out_valid ? head.instr : NOP;
        fetch_out.out_pc       = fetch_out.out_valid ? head.pc : 32'h0;
        fetch_out.out_misalign = fetch_out.out_valid && head.misalign;
    end

    // Redirect discards everything, including a same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= load_pc;
            rd_ptr   <= '0;
            if (bad_redirect) begin
                buf_q[0] <= '{pc: redirect_pc, instr: NOP, misalign: 1'b1};
                wr_ptr   <= PTR_W'(1);
                count    <= (PTR_W + 1)'(1);
            end else begin
                wr_ptr <= '0;
                count  <= '0;
            end
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr, misalign: 1'b0};
                wr_ptr        <= wr_ptr + PTR_W'(1);
                fetch_pc      <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a small instruction memory table.
// Build with +define+IFETCH_ALIGN_CHECK_EN to cover the misalignment marker.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    int          passed = 0;
    int          total  = 0;

    instr_fetch_if fo ();

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_out      (fo.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0010_0113;
            32'h8:   return 32'h0020_81b3;
            32'hc:   return 32'h0030_8233;
            default: return a ^ 32'h5a5a_0003;
        endcase
    endfunction

    assign imem_instr = word(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fo.out_ready   = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fo.out_ready   = 1'b1;
        step();
        total++;
        if (fo.out_valid !== 1'b0)
            $display("FAIL reset_valid got %b exp 0", fo.out_valid);
        else passed++;
        total++;
        if (fo.out_instr !== 32'h0000_0013)
            $display("FAIL reset_instr got %h exp 00000013", fo.out_instr);
        else passed++;
        total++;
        if (fo.out_pc !== 32'h0)
            $display("FAIL reset_pc got %h exp 00000000", fo.out_pc);
        else passed++;
        total++;
        if (fo.out_misalign !== 1'b0)
            $display("FAIL reset_misalign got %b exp 0", fo.out_misalign);
        else passed++;
        total++;
        if (imem_addr !== 32'h0)
            $display("FAIL reset_imem_addr got %h exp 00000000", imem_addr);
        else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        rst_n        = 1'b1;
        fo.out_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(4 * i);
            total++;
            if (fo.out_valid !== 1'b1)
                $display("FAIL stream_valid%0d got %b exp 1", i, fo.out_valid);
            else passed++;
            total++;
            if (fo.out_pc !== exp_pc)
                $display("FAIL stream_pc%0d got %h exp %h", i, fo.out_pc, exp_pc);
            else passed++;
            total++;
            if (fo.out_instr !== word(exp_pc))
                $display("FAIL stream_instr%0d got %h exp %h",
                         i, fo.out_instr, word(exp_pc));
            else passed++;
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        fo.out_ready = 1'b0;
        repeat (5) step();
        total++;
        if (fo.out_valid !== 1'b1)
            $display("FAIL bp_valid got %b exp 1", fo.out_valid);
        else passed++;
        total++;
        if (fo.out_pc !== 32'h0)
            $display("FAIL bp_head_pc got %h exp 00000000", fo.out_pc);
        else passed++;
        total++;
        if (imem_addr !== 32'h8)
            $display("FAIL bp_fetch_pc got %h exp 00000008", imem_addr);
        else passed++;
        fo.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(4 * i);
            total++;
            if (fo.out_valid !== 1'b1 || fo.out_pc !== exp_pc)
                $display("FAIL bp_drain%0d got v=%b pc=%h exp v=1 pc=%h",
                         i, fo.out_valid, fo.out_pc, exp_pc);
            else passed++;
            total++;
            if (fo.out_instr !== word(exp_pc))
                $display("FAIL bp_instr%0d got %h exp %h",
                         i, fo.out_instr, word(exp_pc));
            else passed++;
            step();
        end
    endtask

    task automatic test_redirect_full();
        logic [31:0] exp_pc;
        do_reset();
        fo.out_ready = 1'b0;
        repeat (3) step();
        fo.out_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        total++;
        if (fo.out_valid !== 1'b0)
            $display("FAIL redir_flush got %b exp 0", fo.out_valid);
        else passed++;
        total++;
        if (imem_addr !== 32'h40)
            $display("FAIL redir_addr got %h exp 00000040", imem_addr);
        else passed++;
        step();
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h40 + 32'(4 * i);
            total++;
            if (fo.out_valid !== 1'b1 || fo.out_pc !== exp_pc)
                $display("FAIL redir_seq%0d got v=%b pc=%h exp v=1 pc=%h",
                         i, fo.out_valid, fo.out_pc, exp_pc);
            else passed++;
            total++;
            if (fo.out_instr !== word(exp_pc))
                $display("FAIL redir_instr%0d got %h exp %h",
                         i, fo.out_instr, word(exp_pc));
            else passed++;
            step();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        fo.out_ready = 1'b1;
        repeat (4) step();
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        total++;
        if (fo.out_valid !== 1'b0 || imem_addr !== 32'h0)
            $display("FAIL midrst_state got v=%b addr=%h exp v=0 addr=00000000",
                     fo.out_valid, imem_addr);
        else passed++;
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        step();
        total++;
        if (fo.out_valid !== 1'b1 || fo.out_pc !== 32'h0)
            $display("FAIL midrst_pc0 got v=%b pc=%h exp v=1 pc=00000000",
                     fo.out_valid, fo.out_pc);
        else passed++;
        step();
        total++;
        if (fo.out_pc !== 32'h4)
            $display("FAIL midrst_pc4 got %h exp 00000004", fo.out_pc);
        else passed++;
    endtask

    task automatic test_wrap();
        fo.out_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffc;
        step();
        redirect_valid = 1'b0;
        total++;
        if (fo.out_valid !== 1'b0)
            $display("FAIL wrap_flush got %b exp 0", fo.out_valid);
        else passed++;
        step();
        total++;
        if (fo.out_pc !== 32'hffff_fffc || fo.out_instr !== word(32'hffff_fffc))
            $display("FAIL wrap_top got pc=%h i=%h exp pc=fffffffc i=%h",
                     fo.out_pc, fo.out_instr, word(32'hffff_fffc));
        else passed++;
        step();
        total++;
        if (fo.out_valid !== 1'b1 || fo.out_pc !== 32'h0
            || fo.out_instr !== word(32'h0))
            $display("FAIL wrap_zero got v=%b pc=%h i=%h exp v=1 pc=00000000 i=%h",
                     fo.out_valid, fo.out_pc, fo.out_instr, word(32'h0));
        else passed++;
    endtask

    task automatic test_align();
        fo.out_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        total++;
        if (fo.out_valid !== 1'b1 || fo.out_pc !== 32'h42)
            $display("FAIL align_marker got v=%b pc=%h exp v=1 pc=00000042",
                     fo.out_valid, fo.out_pc);
        else passed++;
        total++;
        if (fo.out_misalign !== 1'b1 || fo.out_instr !== 32'h0000_0013)
            $display("FAIL align_marker_body got m=%b i=%h exp m=1 i=00000013",
                     fo.out_misalign, fo.out_instr);
        else passed++;
        step();
        total++;
        if (fo.out_valid !== 1'b0)
            $display("FAIL align_halt1 got %b exp 0", fo.out_valid);
        else passed++;
        step();
        total++;
        if (fo.out_valid !== 1'b0 || imem_addr !== 32'h42)
            $display("FAIL align_halt2 got v=%b addr=%h exp v=0 addr=00000042",
                     fo.out_valid, imem_addr);
        else passed++;
`else
        total++;
        if (fo.out_valid !== 1'b0 || imem_addr !== 32'h40)
            $display("FAIL align_forced got v=%b addr=%h exp v=0 addr=00000040",
                     fo.out_valid, imem_addr);
        else passed++;
        step();
        total++;
        if (fo.out_valid !== 1'b1 || fo.out_pc !== 32'h40
            || fo.out_misalign !== 1'b0)
            $display("FAIL align_plain got v=%b pc=%h m=%b exp v=1 pc=00000040 m=0",
                     fo.out_valid, fo.out_pc, fo.out_misalign);
        else passed++;
        total++;
        if (fo.out_instr !== word(32'h40))
            $display("FAIL align_plain_instr got %h exp %h",
                     fo.out_instr, word(32'h40));
        else passed++;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        total++;
        if (fo.out_valid !== 1'b0)
            $display("FAIL resume_flush got %b exp 0", fo.out_valid);
        else passed++;
        step();
        total++;
        if (fo.out_valid !== 1'b1 || fo.out_pc !== 32'h80
            || fo.out_misalign !== 1'b0)
            $display("FAIL resume_pc got v=%b pc=%h m=%b exp v=1 pc=00000080 m=0",
                     fo.out_valid, fo.out_pc, fo.out_misalign);
        else passed++;
        step();
        total++;
        if (fo.out_pc !== 32'h84)
            $display("FAIL resume_next got %h exp 00000084", fo.out_pc);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_reset_midstream();
        test_wrap();
        test_align();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
